// File: rtl/rv32m_muldiv.sv
// rtl/rv32m_muldiv.sv - iterative RV32M multiply/divide unit, fixed 33-cycle latency
// Shift-add multiply and restoring divide share one 64-bit working register.
module rv32m_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic [2:0]        op;
  logic [4:0]        rd_q;
  logic [4:0]        cnt;
  logic [XLEN-1:0]   m;
  logic [XLEN-1:0]   a_orig;
  logic [2*XLEN-1:0] p;
  logic              neg;
  logic              div_zero;
  logic              ovf;

  logic              a_signed, b_signed, a_neg, b_neg, is_div_in, is_rem_in;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     msum;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] p_mul, p_div, p_neg;
  logic [XLEN-1:0]   q_fix, r_fix, result_fix;
  logic              accept;

  assign accept    = (state == IDLE) && start && !flush;
  assign a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign is_div_in = funct3[2];
  assign is_rem_in = funct3[2] & funct3[1];
  assign a_neg     = a_signed & op_a[XLEN-1];
  assign b_neg     = b_signed & op_b[XLEN-1];
  assign a_mag     = a_neg ? (~op_a + 1'b1) : op_a;
  assign b_mag     = b_neg ? (~op_b + 1'b1) : op_b;

  // Multiply: high half accumulates, multiplier bits shift out of the low half.
  assign msum  = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
  assign p_mul = {msum, p[XLEN-1:1]};

  // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
  assign diff  = {1'b0, p[2*XLEN-1:XLEN-1]} - {2'b00, m};
  assign p_div = diff[XLEN+1] ? {p[2*XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};

  assign p_neg = ~p + 1'b1;
  assign q_fix = neg ? (~p[XLEN-1:0] + 1'b1) : p[XLEN-1:0];
  assign r_fix = neg ? (~p[2*XLEN-1:XLEN] + 1'b1) : p[2*XLEN-1:XLEN];

  always_comb begin
    result_fix = '0;
    case (op)
      3'b000:                 result_fix = neg ? p_neg[XLEN-1:0] : p[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_fix = neg ? p_neg[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (div_zero)  result_fix = '1;
        else if (ovf)  result_fix = {1'b1, {(XLEN-1){1'b0}}};
        else           result_fix = q_fix;
      end
      default: begin
        if (div_zero)  result_fix = a_orig;
        else if (ovf)  result_fix = '0;
        else           result_fix = r_fix;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && !flush) state_next = CALC;
      CALC: begin
        if (flush)             state_next = IDLE;
        else if (cnt == 5'd31) state_next = FIX;
      end
      FIX:  state_next = flush ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= '0;
      rd_q     <= '0;
      cnt      <= '0;
      m        <= '0;
      a_orig   <= '0;
      p        <= '0;
      neg      <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      if (accept) begin
        op       <= funct3;
        rd_q     <= rd_in;
        cnt      <= '0;
        a_orig   <= op_a;
        m        <= is_div_in ? b_mag : a_mag;
        p        <= {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
        neg      <= is_rem_in ? a_neg : (a_neg ^ b_neg);
        div_zero <= (op_b == '0);
        ovf      <= funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (op_b == '1);
      end
      if (state == CALC && !flush) begin
        p   <= op[2] ? p_div : p_mul;
        cnt <= cnt + 5'd1;
      end
      if (state == FIX && !flush) begin
        result <= result_fix;
        rd_out <= rd_q;
      end
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign stall = (start && (state == IDLE)) || (busy && !done);

endmodule

// File: tb/tb_rv32m_muldiv.sv
// tb/tb_rv32m_muldiv.sv - scoreboard bench for rv32m_muldiv with directed vectors
module tb_rv32m_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad = 0;
  logic [36:0] sb[$];

  rv32m_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .flush(flush), .busy(busy), .stall(stall), .done(done),
    .result(result), .rd_out(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result %h rd %0d expected no write", result, rd_out);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("result", result, e[36:5]);
        chk("rd_out", 32'(rd_out), 32'(e[4:0]));
      end
    end
  end

  // ev_kind: 0 none, 1 extra start, 2 flush, 3 reset; applied at edge ev_edge after accept.
  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp,
                     input int ev_edge, input int ev_kind);
    logic [31:0] prev_res;
    logic [4:0]  prev_rd;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    #1;
    chk("stall_start", 32'(stall), 1);
    chk("idle_busy", 32'(busy), 0);
    prev_res = result;
    prev_rd  = rd_out;
    if (ev_kind < 2) sb.push_back({exp, rd});
    @(posedge clk);
    #1;
    start = 1'b0; funct3 = ~f; op_a = $urandom; op_b = $urandom; rd_in = ~rd;
    chk("busy_e0", 32'(busy), 1);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == ev_edge) begin
        case (ev_kind)
          1: begin start = 1'b1; funct3 = 3'b000; op_a = 32'd7; op_b = 32'd3; rd_in = 5'd9; end
          2: flush = 1'b1;
          3: rst = 1'b1;
          default: ;
        endcase
      end
      @(posedge clk);
      #1;
      start = 1'b0; flush = 1'b0; rst = 1'b0;
      if (n == ev_edge && ev_kind == 2) begin
        chk("flush_busy", 32'(busy), 0);
        chk("flush_done", 32'(done), 0);
        chk("flush_result", result, prev_res);
        chk("flush_rd", 32'(rd_out), 32'(prev_rd));
        break;
      end
      if (n == ev_edge && ev_kind == 3) begin
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_result", result, 0);
        chk("rst_rd", 32'(rd_out), 0);
        break;
      end
      if (n < 33) begin
        chk("calc_busy", 32'(busy), 1);
        chk("calc_stall", 32'(stall), 1);
        chk("calc_done", 32'(done), 0);
      end else if (n == 33) begin
        chk("done_on_e33", 32'(done), 1);
        chk("done_busy", 32'(busy), 1);
        chk("done_stall", 32'(stall), 0);
      end else begin
        chk("done_cleared", 32'(done), 0);
        chk("busy_cleared", 32'(busy), 0);
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0; rd_in = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_stall", 32'(stall), 0);
    chk("reset_result", result, 0);
    chk("reset_rd", 32'(rd_out), 0);
    @(negedge clk);
    rst = 1'b0;

    run(3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 0, 0);
    run(3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 0, 0);
    run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 0, 0);
    run(3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 0, 0);
    run(3'b000, 32'h12345678, 32'h10,       5'd4,  32'h23456780, 0, 0);
    run(3'b100, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, 0, 0);
    run(3'b110, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, 0, 0);
    run(3'b101, 32'd100,      32'd7,        5'd8,  32'd14,       0, 0);
    run(3'b111, 32'd100,      32'd7,        5'd9,  32'd2,        0, 0);
    run(3'b100, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 0, 0);
    run(3'b110, 32'd5,        32'd0,        5'd11, 32'd5,        0, 0);
    run(3'b101, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 0, 0);
    run(3'b111, 32'd5,        32'd0,        5'd13, 32'd5,        0, 0);
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 0, 0);
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        0, 0);
    run(3'b101, 32'd100,      32'd7,        5'd16, 32'd14,       10, 1);
    run(3'b100, 32'hFFFFFFF9, 32'd2,        5'd17, 32'd0,        20, 2);
    run(3'b000, 32'd3,        32'd4,        5'd18, 32'd12,       34, 1);
    run(3'b100, 32'd1000,     32'd3,        5'd19, 32'd0,        15, 3);
    run(3'b000, 32'd6,        32'd7,        5'd0,  32'd42,       0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32m_muldiv.md
# rv32m_muldiv

Iterative RV32M multiply/divide unit sitting beside the ALU in the execute path. It consumes the two register-file read operands and produces a 32-bit result plus destination index for the register-file write port. Completion is signalled by a one-cycle `done` strobe. It executes all eight M-extension operations in a fixed 33-cycle latency and stalls the core while busy.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE.
- `funct3`  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  32  rs1 value (multiplicand / dividend).
- `op_b`  in  32  rs2 value (multiplier / divisor).
- `rd_in`  in  5  destination register index.
- `flush`  in  1  synchronous abort of the in-flight operation.
- `busy`  out  1  operation in flight (CALC, FIX or DONE).
- `stall`  out  1  combinational: `(start & IDLE) | (busy & ~done)`.
- `done`  out  1  one-cycle completion strobe; drives regfile `we`.
- `result`  out  32  operation result; drives regfile `inp_data`.
- `rd_out`  out  5  destination index; drives regfile `rd`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE**
  - `start=1` and `flush=0` at the edge: capture `funct3` and `rd_in`.
  - Convert operands to magnitudes. `op_a` is signed for MULH, MULHSU, DIV, REM. `op_b` is signed for MULH, DIV, REM.
  - Record result sign. Multiply and quotient: sign(a) XOR sign(b). Remainder: sign(a).
  - Flag special cases: divide-by-zero (`op_b==0`), and signed overflow (`op_a==0x80000000`, `op_b==0xFFFFFFFF`, signed div/rem only).
  - Clear the 5-bit counter, then go to CALC.
- **CALC**, 32 iterations, one per edge, counter 0..31:
  - Multiply: shift-add into a 64-bit unsigned product.
  - Divide: restoring division, one quotient bit per iteration, 32-bit partial remainder.
  - At counter==31, go to FIX.
- **FIX**, one edge:
  - Apply the sign (two's-complement negate if the recorded sign is set).
  - Select the word: MUL → low 32 bits; MULH/MULHSU/MULHU → high 32 bits; DIV/DIVU → quotient; REM/REMU → remainder.
  - Special-case overrides:
    - Divide-by-zero: DIV and DIVU → 0xFFFFFFFF; REM and REMU → original `op_a`.
    - Overflow: DIV → 0x80000000; REM → 0.
  - Register `result` and `rd_out`, set `done=1`, go to DONE.
- **DONE**, one cycle: `done=1`, `busy=1`. The next edge goes to IDLE with `done=0`. `start` is ignored in this cycle.
- `start` is ignored in CALC, FIX and DONE.
- Special cases still take the full latency; the datapath runs and its output is discarded.
- `done` pulses even when `rd_out==0`; the register file discards x0 writes.
- `result` and `rd_out` hold their value until the next FIX.

## Timing
- Reset values, following any edge with `rst=1`, from any state: state IDLE, `busy=0`, `done=0`, `result=0`, `rd_out=0`, counter 0. `stall` is then `start`. `rst` has priority over `flush` and `start`.
- Latency, with the accept edge as E0:
  - E1..E32 are iterations; E33 is FIX.
  - `done` is high for exactly the cycle between E33 and E34.
  - `busy` is high from after E0 until E34.
- `stall` is high in the `start` cycle and through every cycle up to, but not including, the `done` cycle.
- Issue rate: back-to-back requests are at best one per 35 cycles. A `start` in the DONE cycle is dropped; the core re-presents it after `stall` falls.
- **`flush`**
  - `flush=1` at any edge in CALC, FIX or DONE returns to IDLE. `busy` and `done` are 0 next cycle; `result` and `rd_out` are unchanged; no write occurs.
  - `flush` and `start` together in IDLE: `start` is ignored.
- Inputs need be valid only in the accept cycle; later changes have no effect.

## Test plan
- MUL 7 × 0xFFFFFFFD, `rd_in`=5 → `result`=0xFFFFFFEB, `rd_out`=5. `done` is high exactly 33 edges after the accept edge, for one cycle. `busy` and `stall` follow the waveform above.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Divide-by-zero: DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIVU 5/0 → 0xFFFFFFFF. Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0. All with 33-cycle latency.
- Second `start` at E10 with different operands → ignored, and the first result is correct. `flush` at E20 → no `done`, `busy`=0 next cycle, `result` unchanged. A new `start` the cycle after `flush` → accepted.
- `rst` asserted at E15 of a DIV → all outputs 0 after that edge and no `done`. A following MUL completes normally.
